// File: rtl/dispatch_lane_reconfig_ctrl.sv
// Sequencer for dispatch lane-mask reconfiguration: stall, drain or flush, gate
// removed lanes, power up added lanes, then release the stall and acknowledge.
module dispatch_lane_reconfig_ctrl #(
  parameter int unsigned                DISPATCH_WIDTH = 4,
  parameter int unsigned                PWR_UP_CYCLES  = 4,
  parameter int unsigned                DRAIN_TIMEOUT  = 256,
  parameter logic [DISPATCH_WIDTH-1:0]  RESET_LANES    = '1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cfgReq_i,
  input  logic [DISPATCH_WIDTH-1:0] cfgLaneActive_i,
  input  logic                      pipeEmpty_i,
  input  logic                      flush_i,
  output logic [DISPATCH_WIDTH-1:0] laneActive_o,
  output logic                      stall_o,
  output logic                      cfgBusy_o,
  output logic                      cfgAck_o,
  output logic                      cfgErr_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_GATE,
    ST_PWRUP,
    ST_DONE,
    ST_ABORT
  } state_e;

  localparam int unsigned               CNT_W      = 16;
  localparam logic [DISPATCH_WIDTH-1:0] LANE0      = DISPATCH_WIDTH'(1);
  localparam logic [DISPATCH_WIDTH-1:0] RESET_MASK = RESET_LANES | LANE0;
  localparam logic [CNT_W-1:0]          DRAIN_LOAD = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]          PWR_LOAD   = CNT_W'(PWR_UP_CYCLES - 1);

  state_e                    state_q, state_d;
  logic [DISPATCH_WIDTH-1:0] lane_active_q, lane_active_d;
  logic [DISPATCH_WIDTH-1:0] new_mask_q, new_mask_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [DISPATCH_WIDTH-1:0] req_mask;

  // Lane 0 can never be switched off, whatever the requester asks for.
  assign req_mask = cfgLaneActive_i | LANE0;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latches).
    state_d       = state_q;
    lane_active_d = lane_active_q;
    new_mask_d    = new_mask_q;
    cnt_d         = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cfgReq_i) begin
          new_mask_d = req_mask;
          if (req_mask == lane_active_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRAIN;
            cnt_d   = DRAIN_LOAD;
          end
        end
      end
      ST_DRAIN: begin
        if (pipeEmpty_i || flush_i) begin
          state_d = ST_GATE;
        end else if (cnt_q == '0) begin
          state_d = ST_ABORT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GATE: begin
        // Removed lanes go dark before any added lane is enabled.
        lane_active_d = lane_active_q & new_mask_q;
        if ((new_mask_q & ~lane_active_q) != '0) begin
          state_d = ST_PWRUP;
          cnt_d   = PWR_LOAD;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_PWRUP: begin
        lane_active_d = new_mask_q;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      lane_active_q <= RESET_MASK;
      new_mask_q    <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      lane_active_q <= lane_active_d;
      new_mask_q    <= new_mask_d;
      cnt_q         <= cnt_d;
    end
  end

  // All status outputs are pure decodes of registered state.
  assign laneActive_o = lane_active_q;
  assign stall_o      = (state_q == ST_DRAIN) || (state_q == ST_GATE) || (state_q == ST_PWRUP);
  assign cfgBusy_o    = (state_q != ST_IDLE);
  assign cfgAck_o     = (state_q == ST_DONE);
  assign cfgErr_o     = (state_q == ST_ABORT);

endmodule
